// File: rtl/conv_seq_engine.sv
// conv_seq_engine
//   Sequential multi-channel 2-D convolution. A start pulse latches a full
//   image, weight set and bias set. One signed fixed-point MAC then walks
//   every output pixel of every output channel. Each pixel takes N MAC
//   cycles, one bias cycle and one write cycle. Zero padding, stride, bias
//   add, optional ReLU and saturation are applied to every pixel.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   conv_en    start pulse, only looked at while idle
//   image      flattened image, word (c,y,x) = (c*image_length+y)*image_width+x
//   weight     flattened kernels, word ((o*ic+c)*weight_length+ky)*weight_width+kx
//   bias       flattened bias, word o belongs to output channel o
//   busy       high from the accepting edge until the completion pulse
//   pix_valid  one-cycle strobe qualifying pix_data / pix_index
//   pix_data   finished pixel value
//   pix_index  word index (o*result_length+oy)*result_width+ox of that pixel
//   result     flattened results, same word order as pix_index
//   out_valid  one-cycle pulse once every pixel has been written
//
// Flattened vectors put word 0 in the most significant bits.
//
// Handshake: there is no back-pressure. conv_en is accepted on the first
// rising edge where it is high and the engine is idle; while busy is high it
// is ignored. pix_valid and out_valid are single-cycle strobes that the
// consumer must capture in the cycle they are high. result is stable from
// out_valid until the next accepted start.
module conv_seq_engine #(
  parameter int data_width     = 16,
  parameter int frac_bits      = 8,
  parameter int input_channel  = 2,
  parameter int output_channel = 2,
  parameter int image_width    = 4,
  parameter int image_length   = 4,
  parameter int weight_width   = 2,
  parameter int weight_length  = 2,
  parameter int stride         = 1,
  parameter int padding        = 0,
  parameter int relu_en        = 0,
  parameter int result_width   = (image_width - weight_width + 2 * padding) / stride + 1,
  parameter int result_length  = (image_length - weight_length + 2 * padding) / stride + 1,
  localparam int pix_num       = output_channel * result_length * result_width,
  localparam int pix_idx_w     = (pix_num > 1) ? $clog2(pix_num) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    conv_en,
  input  logic [input_channel*image_width*image_length*data_width-1:0]                   image,
  input  logic [output_channel*input_channel*weight_width*weight_length*data_width-1:0]  weight,
  input  logic [output_channel*data_width-1:0]    bias,
  output logic                                    busy,
  output logic                                    pix_valid,
  output logic [data_width-1:0]                   pix_data,
  output logic [pix_idx_w-1:0]                    pix_index,
  output logic [pix_num*data_width-1:0]           result,
  output logic                                    out_valid
);

  localparam int IMG_N  = input_channel * image_length * image_width;
  localparam int WGT_N  = output_channel * input_channel * weight_length * weight_width;
  localparam int TAP_N  = input_channel * weight_length * weight_width;
  localparam int ACC_W  = 2 * data_width + $clog2(TAP_N) + 1;
  localparam int IMG_AW = (IMG_N > 1) ? $clog2(IMG_N) : 1;
  localparam int WGT_AW = (WGT_N > 1) ? $clog2(WGT_N) : 1;
  localparam int C_W    = (input_channel > 1) ? $clog2(input_channel) : 1;
  localparam int KY_W   = (weight_length > 1) ? $clog2(weight_length) : 1;
  localparam int KX_W   = (weight_width > 1) ? $clog2(weight_width) : 1;
  localparam int O_W    = (output_channel > 1) ? $clog2(output_channel) : 1;
  localparam int OY_W   = (result_length > 1) ? $clog2(result_length) : 1;
  localparam int OX_W   = (result_width > 1) ? $clog2(result_width) : 1;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-data_width+1){1'b1}}, {(data_width-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_BIAS  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic signed [data_width-1:0] img_q  [IMG_N];
  logic signed [data_width-1:0] img_d  [IMG_N];
  logic signed [data_width-1:0] wgt_q  [WGT_N];
  logic signed [data_width-1:0] wgt_d  [WGT_N];
  logic signed [data_width-1:0] bias_q [output_channel];
  logic signed [data_width-1:0] bias_d [output_channel];
  logic        [data_width-1:0] res_q  [pix_num];
  logic        [data_width-1:0] res_d  [pix_num];

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [C_W-1:0]          c_q, c_d;
  logic [KY_W-1:0]         ky_q, ky_d;
  logic [KX_W-1:0]         kx_q, kx_d;
  logic [O_W-1:0]          o_q, o_d;
  logic [OY_W-1:0]         oy_q, oy_d;
  logic [OX_W-1:0]         ox_q, ox_d;
  logic [pix_idx_w-1:0]    pix_cnt_q, pix_cnt_d;
  logic                    busy_q, busy_d;
  logic                    pix_valid_q, pix_valid_d;
  logic [data_width-1:0]   pix_data_q, pix_data_d;
  logic [pix_idx_w-1:0]    pix_index_q, pix_index_d;
  logic                    out_valid_q, out_valid_d;

  // Tap addressing and MAC operand path.
  int                          tap_iy, tap_ix;
  logic                        tap_ok;
  logic [IMG_AW-1:0]           img_addr;
  logic [WGT_AW-1:0]           wgt_addr;
  logic signed [data_width-1:0]   img_op, wgt_op;
  logic signed [2*data_width-1:0] img_ext, wgt_ext, prod;
  logic signed [ACC_W-1:0]     prod_ext, bias_ext, bias_sh, acc_shr, relu_v;
  logic [data_width-1:0]       sat_v;
  logic                        kx_last, ky_last, c_last, tap_last;
  logic                        ox_last, oy_last, pix_last;

  assign kx_last  = (kx_q == KX_W'(weight_width - 1));
  assign ky_last  = (ky_q == KY_W'(weight_length - 1));
  assign c_last   = (c_q == C_W'(input_channel - 1));
  assign tap_last = kx_last & ky_last & c_last;
  assign ox_last  = (ox_q == OX_W'(result_width - 1));
  assign oy_last  = (oy_q == OY_W'(result_length - 1));
  assign pix_last = (pix_cnt_q == pix_idx_w'(pix_num - 1));

  always_comb begin : tap_path
    // Coordinates in the unpadded image; anything outside reads as zero.
    tap_iy   = int'(oy_q) * stride + int'(ky_q) - padding;
    tap_ix   = int'(ox_q) * stride + int'(kx_q) - padding;
    tap_ok   = (tap_iy >= 0) && (tap_iy < image_length) &&
               (tap_ix >= 0) && (tap_ix < image_width);
    img_addr = '0;
    if (tap_ok) begin
      img_addr = IMG_AW'((int'(c_q) * image_length + tap_iy) * image_width + tap_ix);
    end
    wgt_addr = WGT_AW'(((int'(o_q) * input_channel + int'(c_q)) * weight_length
                        + int'(ky_q)) * weight_width + int'(kx_q));
    img_op   = tap_ok ? img_q[img_addr] : '0;
    wgt_op   = wgt_q[wgt_addr];
    img_ext  = {{data_width{img_op[data_width-1]}}, img_op};
    wgt_ext  = {{data_width{wgt_op[data_width-1]}}, wgt_op};
    prod     = img_ext * wgt_ext;
    prod_ext = {{(ACC_W-2*data_width){prod[2*data_width-1]}}, prod};
    bias_ext = {{(ACC_W-data_width){bias_q[o_q][data_width-1]}}, bias_q[o_q]};
    bias_sh  = bias_ext <<< frac_bits;
  end

  always_comb begin : post_path
    // Arithmetic shift truncates toward minus infinity.
    acc_shr = acc_q >>> frac_bits;
    relu_v  = acc_shr;
    if ((relu_en != 0) && acc_shr[ACC_W-1]) begin
      relu_v = '0;
    end
    if (relu_v > SAT_MAX) begin
      sat_v = SAT_MAX[data_width-1:0];
    end else if (relu_v < SAT_MIN) begin
      sat_v = SAT_MIN[data_width-1:0];
    end else begin
      sat_v = relu_v[data_width-1:0];
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (conv_en) state_d = ST_MAC;
      ST_MAC:   if (tap_last) state_d = ST_BIAS;
      ST_BIAS:  state_d = ST_WRITE;
      ST_WRITE: state_d = pix_last ? ST_DONE : ST_MAC;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs and datapath next values.
  always_comb begin : out_comb
    img_d       = img_q;
    wgt_d       = wgt_q;
    bias_d      = bias_q;
    res_d       = res_q;
    acc_d       = acc_q;
    c_d         = c_q;
    ky_d        = ky_q;
    kx_d        = kx_q;
    o_d         = o_q;
    oy_d        = oy_q;
    ox_d        = ox_q;
    pix_cnt_d   = pix_cnt_q;
    busy_d      = busy_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    pix_index_d = pix_index_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (conv_en) begin
          for (int i = 0; i < IMG_N; i++) begin
            img_d[i] = image[(IMG_N-i)*data_width-1 -: data_width];
          end
          for (int i = 0; i < WGT_N; i++) begin
            wgt_d[i] = weight[(WGT_N-i)*data_width-1 -: data_width];
          end
          for (int i = 0; i < output_channel; i++) begin
            bias_d[i] = bias[(output_channel-i)*data_width-1 -: data_width];
          end
          res_d     = '{default: '0};
          acc_d     = '0;
          c_d       = '0;
          ky_d      = '0;
          kx_d      = '0;
          o_d       = '0;
          oy_d      = '0;
          ox_d      = '0;
          pix_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + prod_ext;
        // kx fastest, then ky, then c; everything wraps to 0 after the last tap.
        if (!kx_last) begin
          kx_d = kx_q + 1'b1;
        end else begin
          kx_d = '0;
          if (!ky_last) begin
            ky_d = ky_q + 1'b1;
          end else begin
            ky_d = '0;
            c_d  = c_last ? '0 : c_q + 1'b1;
          end
        end
      end
      ST_BIAS: begin
        acc_d = acc_q + bias_sh;
      end
      ST_WRITE: begin
        res_d[pix_cnt_q] = sat_v;
        pix_data_d       = sat_v;
        pix_index_d      = pix_cnt_q;
        pix_valid_d      = 1'b1;
        acc_d            = '0;
        pix_cnt_d        = pix_last ? '0 : pix_cnt_q + 1'b1;
        if (!ox_last) begin
          ox_d = ox_q + 1'b1;
        end else begin
          ox_d = '0;
          if (!oy_last) begin
            oy_d = oy_q + 1'b1;
          end else begin
            oy_d = '0;
            o_d  = pix_last ? '0 : o_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      img_q       <= '{default: '0};
      wgt_q       <= '{default: '0};
      bias_q      <= '{default: '0};
      res_q       <= '{default: '0};
      acc_q       <= '0;
      c_q         <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      o_q         <= '0;
      oy_q        <= '0;
      ox_q        <= '0;
      pix_cnt_q   <= '0;
      busy_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_index_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      img_q       <= img_d;
      wgt_q       <= wgt_d;
      bias_q      <= bias_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
      o_q         <= o_d;
      oy_q        <= oy_d;
      ox_q        <= ox_d;
      pix_cnt_q   <= pix_cnt_d;
      busy_q      <= busy_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_index_q <= pix_index_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin : pack_result
    result = '0;
    for (int g = 0; g < pix_num; g++) begin
      result[(pix_num-g)*data_width-1 -: data_width] = res_q[g];
    end
  end

  assign busy      = busy_q;
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_index = pix_index_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conv_seq_engine.sv
// Directed bench for conv_seq_engine. Three instances share clock, reset
// and data inputs: default parameters, relu_en=1, and stride=2/padding=1.
module tb_conv_seq_engine;

  localparam int DW        = 16;
  localparam int IMG_WORDS = 32;
  localparam int WGT_WORDS = 16;
  localparam int PIX       = 18;
  localparam int PIW       = 5;
  localparam int LATENCY   = 181;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en_a = 1'b0, en_r = 1'b0, en_s = 1'b0;
  logic [IMG_WORDS*DW-1:0] image;
  logic [WGT_WORDS*DW-1:0] weight;
  logic [2*DW-1:0]         bias;

  logic busy_a, pv_a, ov_a; logic [DW-1:0] pd_a; logic [PIW-1:0] pi_a; logic [PIX*DW-1:0] res_a;
  logic busy_r, pv_r, ov_r; logic [DW-1:0] pd_r; logic [PIW-1:0] pi_r; logic [PIX*DW-1:0] res_r;
  logic busy_s, pv_s, ov_s; logic [DW-1:0] pd_s; logic [PIW-1:0] pi_s; logic [PIX*DW-1:0] res_s;

  int sel = 0;
  logic m_busy, m_pv, m_ov; logic [DW-1:0] m_pd; logic [PIW-1:0] m_pi; logic [PIX*DW-1:0] m_res;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_res[PIX];
  int checks = 0;
  int errors = 0;

  conv_seq_engine dut_a (
    .clk(clk), .reset(reset), .conv_en(en_a), .image(image), .weight(weight), .bias(bias),
    .busy(busy_a), .pix_valid(pv_a), .pix_data(pd_a), .pix_index(pi_a), .result(res_a),
    .out_valid(ov_a));

  conv_seq_engine #(.relu_en(1)) dut_r (
    .clk(clk), .reset(reset), .conv_en(en_r), .image(image), .weight(weight), .bias(bias),
    .busy(busy_r), .pix_valid(pv_r), .pix_data(pd_r), .pix_index(pi_r), .result(res_r),
    .out_valid(ov_r));

  conv_seq_engine #(.stride(2), .padding(1)) dut_s (
    .clk(clk), .reset(reset), .conv_en(en_s), .image(image), .weight(weight), .bias(bias),
    .busy(busy_s), .pix_valid(pv_s), .pix_data(pd_s), .pix_index(pi_s), .result(res_s),
    .out_valid(ov_s));

  // Clock
  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      1: begin m_busy = busy_r; m_pv = pv_r; m_ov = ov_r; m_pd = pd_r; m_pi = pi_r; m_res = res_r; end
      2: begin m_busy = busy_s; m_pv = pv_s; m_ov = ov_s; m_pd = pd_s; m_pi = pi_s; m_res = res_s; end
      default: begin m_busy = busy_a; m_pv = pv_a; m_ov = ov_a; m_pd = pd_a; m_pi = pi_a; m_res = res_a; end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_image(input logic [DW-1:0] v);
    for (int i = 0; i < IMG_WORDS; i++) image[(IMG_WORDS-i)*DW-1 -: DW] = v;
  endtask

  task automatic set_weight(input logic [DW-1:0] v);
    for (int i = 0; i < WGT_WORDS; i++) weight[(WGT_WORDS-i)*DW-1 -: DW] = v;
  endtask

  task automatic set_bias(input logic [DW-1:0] b0, input logic [DW-1:0] b1);
    bias = {b0, b1};
  endtask

  task automatic set_en(input int s, input logic v);
    case (s)
      1: en_r = v;
      2: en_s = v;
      default: en_a = v;
    endcase
  endtask

  // Scoreboard loading
  task automatic expect_all(input logic [DW-1:0] v0, input logic [DW-1:0] v1);
    exp_q.delete();
    for (int i = 0; i < PIX; i++) begin
      exp_res[i] = (i < PIX/2) ? v0 : v1;
      exp_q.push_back(exp_res[i]);
    end
  endtask

  // 3x3 output of the stride-2 / pad-1 instance; 1.0 per valid tap per channel.
  task automatic expect_sp();
    logic [DW-1:0] pat [9];
    pat = '{16'h0200, 16'h0400, 16'h0200,
            16'h0400, 16'h0800, 16'h0400,
            16'h0200, 16'h0400, 16'h0200};
    exp_q.delete();
    for (int i = 0; i < PIX; i++) begin
      exp_res[i] = pat[i % 9];
      exp_q.push_back(exp_res[i]);
    end
  endtask

  // Returns just after the accepting edge.
  task automatic start(input int s, input bit hold);
    @(negedge clk);
    sel = s;
    set_en(s, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_en(s, 1'b0);
  endtask

  // Counts edges after the accepting edge until out_valid (bounded).
  task automatic monitor(input int s, input bit disturb);
    int cyc;
    int pix;
    bit done;
    logic [DW-1:0] e;
    cyc = 0;
    pix = 0;
    done = 0;
    while (!done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_pv) begin
        if (exp_q.size() == 0) begin
          check("pix_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pix_data", m_pd, e);
          check("pix_index", m_pi, pix);
        end
        pix++;
      end
      if (m_ov) done = 1;
      if (disturb && cyc == 30) set_image(16'h0000);
      if (disturb && cyc == 50) set_en(s, 1'b1);
      if (disturb && cyc == 51) set_en(s, 1'b0);
    end
    check("done_latency", cyc, LATENCY);
    check("busy_at_done", m_busy, 0);
    check("pix_count", pix, PIX);
    for (int i = 0; i < PIX; i++) check("result_word", m_res[(PIX-i)*DW-1 -: DW], exp_res[i]);
    exp_q.delete();
  endtask

  initial begin
    int ov_cnt;
    set_image(16'h0100);
    set_weight(16'h0100);
    set_bias(16'h0000, 16'h0000);

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_pix_valid", pv_a, 0);
    check("rst_out_valid", ov_a, 0);
    check("rst_pix_data", pd_a, 0);
    check("rst_pix_index", pi_a, 0);
    check("rst_result", |res_a, 0);
    @(negedge clk);
    reset = 1'b1;

    // All ones, zero bias
    expect_all(16'h0800, 16'h0800);
    start(0, 0);
    check("busy_after_start", busy_a, 1);
    monitor(0, 0);

    // Per-channel bias
    set_bias(16'h0080, 16'hFF00);
    expect_all(16'h0880, 16'h0700);
    start(0, 0);
    monitor(0, 0);

    // Negative weights, with and without ReLU
    set_bias(16'h0000, 16'h0000);
    set_weight(16'hFF00);
    expect_all(16'hF800, 16'hF800);
    start(0, 0);
    monitor(0, 0);
    expect_all(16'h0000, 16'h0000);
    start(1, 0);
    monitor(1, 0);

    // Saturation both ways
    set_image(16'h7F00);
    set_weight(16'h7F00);
    expect_all(16'h7FFF, 16'h7FFF);
    start(0, 0);
    monitor(0, 0);
    set_weight(16'h8100);
    expect_all(16'h8000, 16'h8000);
    start(0, 0);
    monitor(0, 0);

    // Stride 2, padding 1
    set_image(16'h0100);
    set_weight(16'h0100);
    expect_sp();
    start(2, 0);
    monitor(2, 0);

    // Start while busy and image change mid-run are ignored
    expect_all(16'h0800, 16'h0800);
    start(0, 0);
    monitor(0, 1);
    set_image(16'h0100);

    // conv_en held high: restart on the IDLE cycle right after DONE
    expect_all(16'h0800, 16'h0800);
    start(0, 1);
    monitor(0, 0);
    @(posedge clk);
    #1;
    check("restart_busy", busy_a, 1);
    check("restart_out_valid", ov_a, 0);
    set_en(0, 1'b0);
    expect_all(16'h0800, 16'h0800);
    monitor(0, 0);

    // Reset mid-run
    start(0, 0);
    for (int k = 1; k < 100; k++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_pix_valid", pv_a, 0);
    check("abort_pix_data", pd_a, 0);
    check("abort_pix_index", pi_a, 0);
    check("abort_result", |res_a, 0);
    ov_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (ov_a) ov_cnt++;
      if (k == 3) reset = 1'b1;
    end
    check("abort_no_out_valid", ov_cnt, 0);
    check("abort_idle_busy", busy_a, 0);
    check("abort_result_held", |res_a, 0);

    // Fresh start after reset
    expect_all(16'h0800, 16'h0800);
    start(0, 0);
    monitor(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
